logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the integer ALU. It generalises the fixed 4-bit AND gate to an N-bit, 8-operation unit with an accumulate mode, result flags, valid/ready flow control and a completed-operation counter. It sits beside the arithmetic unit in the Int_ALU datapath and has two cycles of latency.

Parameters:
WIDTH, 4, operand/result width in bits (≥1)
COUNT_W, 8, width of completed-operation counter (≥1)

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  unit can accept bundle this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select
acc_en  input  1  use accumulator in place of A
acc_clr  input  1  clear accumulator
out_valid  output  1  result bundle valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
ones  output  1  result == all ones
parity  output  1  XOR-reduction of result
op_count  output  COUNT_W  count of output handshakes, wraps

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, ones=0, parity=0, acc=0, op_count=0. After reset deasserts, in_ready=1 in the first cycle.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A. All operations are bitwise over WIDTH with no carries.
- Effective A (a_eff): acc_clr ? 0 : (acc_en ? acc : a).
- Input accept when in_valid && in_ready.
- On accept:
  - s1_res <= f(op, a_eff, b); s1_valid <= 1.
  - acc <= f(op, a_eff, b). The accumulator updates on every accept, regardless of acc_en.
- acc_clr with no accept: acc <= 0. With accept: a_eff = 0 and acc <= the new result.
- Stage 2 registers s1_res plus its flags into result/zero/ones/parity/out_valid.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - This is a combinational out_ready→in_ready path; it is intentional. No skid buffer.
- When s2_adv is true, s2 loads from s1 and s2_valid <= s1_valid.
- When s1_adv is true and there is no accept, s1_valid <= 0.
- Stalled stages hold all data and flags stable while valid. result must not change while out_valid && !out_ready.
- Latency: bundle accepted in cycle N → out_valid in cycle N+2 when unstalled. Throughput is 1 per cycle with out_ready held high.
- op_count increments on out_valid && out_ready and wraps from 2^COUNT_W−1 to 0.
- Accumulator chaining: back-to-back acc_en accepts use the result of the immediately preceding accept. No hazard exists, because acc is written at accept time.
- Input bundles presented without in_valid are ignored. Flags of an empty s2 hold their last value, and are meaningful only with out_valid.
- Reset mid-operation discards all in-flight bundles; no output is produced for them.

Decomposition:
- Shared package logic_unit_pkg:
  - opcode constants OP_AND..OP_PASS (3-bit)
  - op_t typedef
- One natural sub-module, logic_unit_core: purely combinational f(op, a_eff, b) plus flag generation (zero/ones/parity), parametrised by WIDTH. The top holds the pipeline registers, accumulator, handshake and counter.

Test Plan:
1. WIDTH=4, out_ready=1. Inputs a=1111,b=0000,AND; then a=0000,b=1111,AND; then a=1111,b=1111,AND; then a=1111,b=0110,AND, one per cycle.
   → results 0000(zero=1), 0000(zero=1), 1111(ones=1,parity=0), 0110(parity=0), each 2 cycles after its accept; op_count=4.
2. Sweep all 8 ops with a=1100,b=1010.
   → 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1100; parity 1,1,0,1,1,0,0,0.
3. Accumulate:
   - acc_clr=1 with a=xxxx,b=0101,OR → 0101.
   - Then acc_en=1,b=0011,XOR → 0110.
   - Then acc_en=1,b=1111,NAND → 1001.
   - acc reads 1001 afterwards.
4. Backpressure: stream 4 bundles, hold out_ready=0 for 3 cycles.
   - in_ready falls after 2 accepts.
   - result is stable while stalled.
   - Releasing out_ready delivers all 4 in order with no loss or duplicates; op_count=4.
5. Reset mid-stream: assert rst asynchronously (between clock edges) with s1 and s2 valid.
   → out_valid=0, op_count=0 and acc=0 immediately; no stale result appears after release.
6. Counter wrap, COUNT_W=2: 5 handshakes → op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcode encoding shared by the logic unit pipeline and its core
package logic_unit_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_t;
endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise function plus zero/ones/parity flags
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zero_o,
  output logic             ones_o,
  output logic             parity_o
);
  // select the bitwise operation; NOT and PASS ignore b
  always_comb begin
    res_o = a_i;
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_NOT:  res_o = ~a_i;
      OP_PASS: res_o = a_i;
      default: res_o = a_i;
    endcase
  end
  assign zero_o   = res_o == '0;
  assign ones_o   = &res_o;
  assign parity_o = ^res_o;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with accumulator and op counter
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               ones,
  output logic               parity,
  output logic [COUNT_W-1:0] op_count
);
  logic [WIDTH-1:0] acc_q, a_eff, f_res, s1_res_q;
  logic             f_zero, f_ones, f_par, s1_zero_q, s1_ones_q, s1_par_q, s1_valid_q;
  logic             s2_adv, s1_adv, accept;
  assign a_eff    = acc_clr ? '0 : (acc_en ? acc_q : a);
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;
  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (op_t'(op)),
    .a_i     (a_eff),
    .b_i     (b),
    .res_o   (f_res),
    .zero_o  (f_zero),
    .ones_o  (f_ones),
    .parity_o(f_par)
  );
  // stage 1 and accumulator: capture a new result on accept, drain when downstream moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_ones_q  <= 1'b0;
      s1_par_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_res_q   <= f_res;
        s1_zero_q  <= f_zero;
        s1_ones_q  <= f_ones;
        s1_par_q   <= f_par;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (accept) acc_q <= f_res;
      else if (acc_clr) acc_q <= '0;
    end
  end
  // stage 2: output register; data only replaced by a valid bundle so flags of an empty stage hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      parity    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        result <= s1_res_q;
        zero   <= s1_zero_q;
        ones   <= s1_ones_q;
        parity <= s1_par_q;
      end
    end
  end
  // count output handshakes, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count <= '0;
    else if (out_valid && out_ready) op_count <= op_count + COUNT_W'(1);
  end
endmodule
